serial_subtractor_8bit: RTL and testbench



---
 rtl/serial_subtractor_8bit_pkg.sv | 20 ++
 rtl/serial_subtractor_8bit_full_subtractor.sv | 17 +
 rtl/serial_subtractor_8bit.sv | 133 +++++++++++++
 tb/tb_serial_subtractor_8bit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the bit-counter width helper.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter must be able to represent WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_8bit_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bw_in, with borrow out.
// Counterpart of the adder's full-adder cell; intended for reuse in a ripple subtractor.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bw_in,
    output logic d,
    output logic bw_out
);

    logic w_xy;

    assign w_xy   = x ^ y;
    assign d      = w_xy ^ bw_in;
    assign bw_out = (~x & y) | (~w_xy & bw_in);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor D = a - b - bi, one bit per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output ovf is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor_8bit
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bw;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;

    logic             w_d;
    logic             w_bw_next;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor u_cell (
        .x      (r_a_sh[0]),
        .y      (r_b_sh[0]),
        .bw_in  (r_bw),
        .d      (w_d),
        .bw_out (w_bw_next)
    );

    // New bit enters at the MSB so after WIDTH shifts the LSB-first stream is in place.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

`ifdef SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == SHIFT && r_cnt == LAST_CNT) begin
            // w_d is the result MSB on the final shift edge.
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_bw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= SHIFT;
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_bw    <= bi;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_res  <= w_res_next;
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_bw   <= w_bw_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_d     <= w_res_next;
                        r_bout  <= w_bw_next;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign D    = r_d;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed self-checking bench for serial_subtractor_8bit (ovf checks when SUB_OVERFLOW_EN is defined).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_subtractor_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic       busy;
    logic       done;
    logic [7:0] D;
    logic       bout;
`ifdef SUB_OVERFLOW_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic last_ovf;

    always #5 clk = ~clk;

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .bout  (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Issues one single-cycle start and observes the next 12 cycles.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbi,
                         output logic [7:0] od, output logic ob, output int busy_n,
                         output int done_idx, output int done_n, output int d_glitch);
        logic [7:0] prev;
        od = 8'h00; ob = 1'b0; busy_n = 0; done_idx = -1; done_n = 0; d_glitch = 0;
        last_ovf = 1'b0;
        @(negedge clk);
        a = ta; b = tb_v; bi = tbi; start = 1'b1;
        prev = D;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy) busy_n++;
            if (busy && D !== prev) d_glitch++;
            if (done) begin
                done_n++;
                if (done_idx < 0) done_idx = i;
                od = D;
                ob = bout;
`ifdef SUB_OVERFLOW_EN
                last_ovf = ovf;
`endif
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, D, bout} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b D=%h bout=%b, required all 0", busy, done, D, bout);
        end
`ifdef SUB_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
        end
`endif
        rst = 1'b0;
        $display("reset: busy=%b done=%b D=%h bout=%b", busy, done, D, bout);
    endtask

    task automatic test_vectors();
        logic [7:0] va  [6] = '{8'h1C, 8'h1D, 8'h9C, 8'hF0, 8'h00, 8'hFF};
        logic [7:0] vb  [6] = '{8'hF0, 8'hF2, 8'hFC, 8'h1C, 8'h00, 8'hFF};
        logic       vbi [6] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        logic [7:0] ed  [6] = '{8'h2B, 8'h2A, 8'hA0, 8'hD4, 8'hFF, 8'h00};
        logic       eb  [6] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
        logic [7:0] od;
        logic       ob;
        int busy_n, done_idx, done_n, d_glitch;
        for (int v = 0; v < 6; v++) begin
            do_op(va[v], vb[v], vbi[v], od, ob, busy_n, done_idx, done_n, d_glitch);
            $display("op a=%h b=%h bi=%b -> D=%h bout=%b busy_cycles=%0d done_at=%0d",
                     va[v], vb[v], vbi[v], od, ob, busy_n, done_idx);
            checks++;
            if (od !== ed[v] || ob !== eb[v]) begin
                errors++;
                $display("FAIL result_%0d: D=%h bout=%b, required D=%h bout=%b", v, od, ob, ed[v], eb[v]);
            end
            checks++;
            if (busy_n != 8 || done_n != 1 || done_idx != 8) begin
                errors++;
                $display("FAIL timing_%0d: busy_cycles=%0d done_pulses=%0d done_at=%0d, required 8/1/8",
                         v, busy_n, done_n, done_idx);
            end
            checks++;
            if (d_glitch != 0) begin
                errors++;
                $display("FAIL d_hold_%0d: D changed in %0d busy cycles, required 0", v, d_glitch);
            end
        end
    endtask

    task automatic test_handshake();
        int done_n = 0;
        logic [7:0] d1 = 8'h00;
        logic       b1 = 1'b0;
        @(negedge clk);
        a = 8'h05; b = 8'h03; bi = 1'b0; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) begin a = 8'h77; b = 8'h11; end
            if (done) begin done_n++; d1 = D; b1 = bout; end
        end
        start = 1'b0;
        $display("held start: done_pulses=%0d D=%h bout=%b", done_n, d1, b1);
        checks++;
        if (done_n != 1 || d1 !== 8'h02 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL held_start: pulses=%0d D=%h bout=%b, required 1 D=02 bout=0", done_n, d1, b1);
        end
        // Start was still high at the first IDLE edge, so a second op (new operands) is in flight.
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin done_n++; d1 = D; b1 = bout; end
        end
        $display("reaccept: done_pulses=%0d D=%h bout=%b", done_n, d1, b1);
        checks++;
        if (done_n != 1 || d1 !== 8'h66 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL reaccept: pulses=%0d D=%h bout=%b, required 1 D=66 bout=0", done_n, d1, b1);
        end
    endtask

    task automatic test_reset_mid_op();
        int done_n = 0;
        logic [7:0] od;
        logic       ob;
        int busy_n, done_idx, d_glitch;
        @(negedge clk);
        a = 8'h80; b = 8'h01; bi = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-op reset: busy=%b done=%b D=%h bout=%b", busy, done, D, bout);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || D !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b D=%h bout=%b, required 0/0/00/0", busy, done, D, bout);
        end
        for (int i = 0; i < 12; i++) begin
            if (done || busy) done_n++;
            @(negedge clk);
        end
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d active cycles after abort, required 0", done_n);
        end
        do_op(8'h80, 8'h01, 1'b0, od, ob, busy_n, done_idx, done_n, d_glitch);
        $display("op a=80 b=01 bi=0 -> D=%h bout=%b ovf=%b done_at=%0d", od, ob, last_ovf, done_idx);
        checks++;
        if (od !== 8'h7F || ob !== 1'b0 || done_n != 1) begin
            errors++;
            $display("FAIL after_abort: D=%h bout=%b pulses=%0d, required D=7F bout=0 1", od, ob, done_n);
        end
`ifdef SUB_OVERFLOW_EN
        checks++;
        if (last_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b, required 1", last_ovf);
        end
        do_op(8'h05, 8'h03, 1'b0, od, ob, busy_n, done_idx, done_n, d_glitch);
        $display("op a=05 b=03 bi=0 -> D=%h bout=%b ovf=%b", od, ob, last_ovf);
        checks++;
        if (last_ovf !== 1'b0 || od !== 8'h02) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b D=%h, required ovf=0 D=02", last_ovf, od);
        end
`endif
    endtask

    task automatic test_rst_start_same_cycle();
        int active = 0;
        @(negedge clk);
        a = 8'h10; b = 8'h01; bi = 1'b0; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy || done) active++;
            @(negedge clk);
        end
        $display("rst+start: active_cycles=%0d D=%h", active, D);
        checks++;
        if (active != 0 || D !== 8'h00) begin
            errors++;
            $display("FAIL rst_wins: active=%0d D=%h, required 0 and D=00", active, D);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_handshake();
        test_reset_mid_op();
        test_rst_start_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
